// File: rtl/dram_window_fetch_if.sv
// dram_window_fetch_if: fetch request/response plus DRAM read port.
// slave is the fetch engine; master is the requester and DRAM side.
interface dram_window_fetch_if #(
   parameter int A_WIDTH = 19,
   parameter int MASKLEN = 392
);
   logic               start;
   logic [9:0]         center_col;
   logic [8:0]         center_row;
   logic               busy;
   logic               done;
   logic [MASKLEN-1:0] window;
   logic               dram_ren;
   logic [A_WIDTH-1:0] dram_raddr;
   logic [MASKLEN-1:0] dram_rdata;

   modport slave (
      input  start, center_col, center_row, dram_rdata,
      output busy, done, window, dram_ren, dram_raddr
   );

   modport master (
      output start, center_col, center_row, dram_rdata,
      input  busy, done, window, dram_ren, dram_raddr
   );
endinterface

// File: rtl/dram_window_fetch.sv
// dram_window_fetch: reads the KxK neighbourhood around a centre pixel
// from image DRAM and packs it row-major into one window vector.
module dram_window_fetch #(
   parameter int D_WIDTH = 8,
   parameter int A_WIDTH = 19,
   parameter int MASKLEN = 392,
   parameter int IMG_W   = 640,
   parameter int IMG_H   = 480,
   parameter int K       = 7,
   parameter logic [D_WIDTH-1:0] PAD = 8'h00
) (
   input logic clk,
   input logic rst,
   dram_window_fetch_if.slave bus
);

   localparam int HALF = (K - 1) / 2;
   localparam int NPOS = K * K;
   localparam int KW   = $clog2(NPOS);
   localparam int CW   = $clog2(K);

   localparam logic signed [10:0] HALF_S  = 11'(HALF);
   localparam logic signed [10:0] IMG_W_S = 11'(IMG_W);
   localparam logic signed [10:0] IMG_H_S = 11'(IMG_H);
   localparam logic signed [20:0] ROW_STEP = 21'(IMG_W);
   localparam logic signed [20:0] BASE_OFS = 21'(HALF * IMG_W);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } state_t;

   // Shift-add form of row*IMG_W, used once per fetch for the first row base.
   function automatic logic signed [20:0] row_times_w(
      input logic [8:0] row
   );
      logic [20:0] acc;
      acc = '0;
      for (int i = 0; i < 12; i++)
         if (IMG_W[i]) acc = acc + (21'(row) << i);
      return $signed(acc);
   endfunction

   state_t               state;
   logic [CW-1:0]        c;
   logic [KW-1:0]        k;
   logic signed [10:0]   ir;
   logic signed [10:0]   ic;
   logic signed [10:0]   ic_first;
   logic signed [20:0]   row_base;

   logic                 iss_v;
   logic                 iss_inr;
   logic [KW-1:0]        iss_k;
   logic                 pipe_v;
   logic                 pipe_inr;
   logic [KW-1:0]        pipe_k;

   logic                 in_range;
   logic signed [20:0]   addr;
   logic signed [10:0]   ir0;
   logic signed [10:0]   ic0;
   logic                 unused_bits;

   always_comb begin
      in_range = (ir >= 11'sd0) && (ir < IMG_H_S) &&
                 (ic >= 11'sd0) && (ic < IMG_W_S);
   end

   assign addr = row_base + 21'(ic);
   assign ir0  = $signed({2'b00, bus.center_row}) - HALF_S;
   assign ic0  = $signed({1'b0, bus.center_col}) - HALF_S;

   assign unused_bits = ^{bus.dram_rdata[MASKLEN-1:D_WIDTH],
                          addr[20:A_WIDTH]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         c              <= '0;
         k              <= '0;
         ir             <= '0;
         ic             <= '0;
         ic_first       <= '0;
         row_base       <= '0;
         iss_v          <= 1'b0;
         iss_inr        <= 1'b0;
         iss_k          <= '0;
         pipe_v         <= 1'b0;
         pipe_inr       <= 1'b0;
         pipe_k         <= '0;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
         bus.window     <= '0;
         bus.dram_ren   <= 1'b0;
         bus.dram_raddr <= '0;
      end else begin
         bus.done     <= 1'b0;
         bus.dram_ren <= 1'b0;
         iss_v        <= 1'b0;
         // Second stage lines the issued position up with its read data.
         pipe_v       <= iss_v;
         pipe_k       <= iss_k;
         pipe_inr     <= iss_inr;

         if (pipe_v)
            bus.window[int'(pipe_k)*D_WIDTH +: D_WIDTH] <=
               pipe_inr ? bus.dram_rdata[D_WIDTH-1:0] : PAD;

         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  c        <= '0;
                  k        <= '0;
                  ir       <= ir0;
                  ic       <= ic0;
                  ic_first <= ic0;
                  row_base <= row_times_w(bus.center_row) - BASE_OFS;
                  bus.busy <= 1'b1;
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               iss_v        <= 1'b1;
               iss_k        <= k;
               iss_inr      <= in_range;
               bus.dram_ren <= in_range;
               if (in_range)
                  bus.dram_raddr <= addr[A_WIDTH-1:0];
               k <= k + 1'b1;
               if (c == CW'(K - 1)) begin
                  c        <= '0;
                  ic       <= ic_first;
                  ir       <= ir + 11'sd1;
                  row_base <= row_base + ROW_STEP;
               end else begin
                  c  <= c + 1'b1;
                  ic <= ic + 11'sd1;
               end
               if (k == KW'(NPOS - 1))
                  state <= DRAIN;
            end
            DRAIN: begin
               state <= DONE;
            end
            DONE: begin
               bus.done <= 1'b1;
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
